// File: rtl/gauss_jordan_solver_if.sv
// Producer/consumer bus of the Gauss-Jordan solver: augmented matrix in, roots and status out.
interface gauss_jordan_solver_if #(
   parameter int MATRIX_SIZE = 3,
   parameter int DATA_WIDTH  = 32
);
   logic                                              i_calc_cmd;
   logic [DATA_WIDTH*MATRIX_SIZE*(MATRIX_SIZE+1)-1:0] i_matrix;
   logic [DATA_WIDTH*MATRIX_SIZE-1:0]                 o_roots;
   logic                                              o_ready;
   logic                                              o_busy;
   logic                                              o_singular;

   modport master (output i_calc_cmd, i_matrix,
                   input  o_roots, o_ready, o_busy, o_singular);
   modport slave  (input  i_calc_cmd, i_matrix,
                   output o_roots, o_ready, o_busy, o_singular);
endinterface

// File: rtl/gauss_jordan_solver.sv
// N x N fixed-point Gauss-Jordan solver with one serial reciprocal divider and one multiplier.
// GAUSS_PARTIAL_PIVOT_EN selects largest-magnitude pivoting instead of first-nonzero pivoting.
//
// state  | meaning
// IDLE   | wait for i_calc_cmd, capture matrix
// PIVOT  | scan column k for the pivot row, one row per cycle
// SWAP   | exchange row k with the pivot row, arm the divider
// RECIP  | restoring divide 2^(2F) / pivot, one quotient bit per cycle
// NORM   | scale row k by the reciprocal
// ELIM_F | latch elimination factor of row i
// ELIM   | subtract factor * row k from row i
// NEXT   | advance to the next column
// DONE   | publish roots / singular flag
module gauss_jordan_solver #(
   parameter int MATRIX_SIZE = 3,
   parameter int DATA_WIDTH  = 32,
   parameter int FRAC_BITS   = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   gauss_jordan_solver_if.slave bus
);
   localparam int N  = MATRIX_SIZE;
   localparam int W  = DATA_WIDTH;
   localparam int F  = FRAC_BITS;
   localparam int QW = W + F;
   localparam int CW = $clog2(QW);
   localparam int RB = $clog2(N);
   localparam int CB = $clog2(N + 1);
   localparam logic [RB-1:0]       LAST_ROW = RB'(N - 1);
   localparam logic [CB-1:0]       LAST_COL = CB'(N);
   localparam logic [RB-1:0]       R_ONE    = RB'(1);
   localparam logic [CB-1:0]       C_ONE    = CB'(1);
   localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]       CNT_INIT = CW'(QW - 1);
   localparam logic [QW-1:0]       DIV_INIT = QW'(1) << (2 * F);
   localparam logic signed [W-1:0] S_MAX    = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] S_MIN    = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W-1:0] ONE      = W'(1) << F;

   typedef enum logic [3:0] {IDLE, PIVOT, SWAP, RECIP, NORM, ELIM_F, ELIM, NEXT, DONE} state_t;
   state_t state_q, state_d;

   logic signed [W-1:0] a [N][N+1];
   logic [RB-1:0]       k, r, i, piv_row, first_i, nxt_i;
   logic [CB-1:0]       j;
   logic signed [W-1:0] fac, cur, recip;
   logic [W-1:0]        d_mag, rem;
   logic                d_neg, found, scan_end, elim_last, rem_ge;
   logic [QW-1:0]       quot, div_sr;
   logic [CW-1:0]       div_cnt;
   logic [W:0]          rem_sh, rem_sub;
   int                  ni;
`ifdef GAUSS_PARTIAL_PIVOT_EN
   logic [W-1:0]        best_mag, cur_mag, win_mag;
`endif
   logic [RB-1:0]       win_row;

   function automatic logic signed [W-1:0] sat_w(input logic signed [2*W-1:0] v);
      if (&v[2*W-1:W-1] || ~|v[2*W-1:W-1]) return v[W-1:0];
      return v[2*W-1] ? S_MIN : S_MAX;
   endfunction

   function automatic logic signed [W-1:0] mul(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
      logic signed [2*W-1:0] p;
      p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
      return sat_w(p >>> F);
   endfunction

   function automatic logic signed [W-1:0] sat_sub(input logic signed [W-1:0] x, input logic signed [W-1:0] y);
      return sat_w($signed({{W{x[W-1]}}, x}) - $signed({{W{y[W-1]}}, y}));
   endfunction

   // -2^(W-1) maps to 2^(W-1) as unsigned, i.e. the largest magnitude
   function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
      return v[W-1] ? -v : v;
   endfunction

   always_comb begin
      cur      = a[r][CB'(k)];
      win_row  = r;
      found    = 1'b0;
      scan_end = 1'b0;
`ifdef GAUSS_PARTIAL_PIVOT_EN
      cur_mag  = mag(cur);
      win_mag  = best_mag;
      win_row  = piv_row;
      if (r == k || cur_mag > best_mag) begin
         win_mag = cur_mag;
         win_row = r;
      end
      scan_end = (r == LAST_ROW);
      found    = (win_mag != '0);
`else
      found    = (cur != '0);
      scan_end = found || (r == LAST_ROW);
`endif
   end

   always_comb begin
      ni = int'(i) + 1;
      if (ni == int'(k)) ni = ni + 1;
   end
   assign elim_last = (ni > N - 1);
   assign nxt_i     = RB'(ni);
   assign first_i   = (k == '0) ? R_ONE : '0;

   assign rem_sh  = {rem, div_sr[QW-1]};
   assign rem_ge  = (rem_sh >= {1'b0, d_mag});
   assign rem_sub = rem_sh - {1'b0, d_mag};

   always_comb begin
      if (|quot[QW-1:W-1]) recip = d_neg ? S_MIN : S_MAX;
      else                 recip = d_neg ? -$signed(quot[W-1:0]) : $signed(quot[W-1:0]);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.i_calc_cmd) state_d = PIVOT;
         PIVOT:   if (scan_end) state_d = found ? SWAP : DONE;
         SWAP:    state_d = RECIP;
         RECIP:   if (div_cnt == '0) state_d = NORM;
         NORM:    if (j == LAST_COL) state_d = ELIM_F;
         ELIM_F:  state_d = ELIM;
         ELIM:    if (j == LAST_COL) state_d = elim_last ? NEXT : ELIM_F;
         NEXT:    state_d = (k == LAST_ROW) ? DONE : PIVOT;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bus.o_roots    <= '0;
         bus.o_ready    <= 1'b0;
         bus.o_busy     <= 1'b0;
         bus.o_singular <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.i_calc_cmd) begin
               for (int rr = 0; rr < N; rr++)
                  for (int cc = 0; cc <= N; cc++)
                     a[rr][cc] <= bus.i_matrix[W*(rr*(N+1)+cc) +: W];
               bus.o_ready    <= 1'b0;
               bus.o_singular <= 1'b0;
               bus.o_busy     <= 1'b1;
               k              <= '0;
               r              <= '0;
            end
            PIVOT: begin
               piv_row <= win_row;
               r       <= r + R_ONE;
`ifdef GAUSS_PARTIAL_PIVOT_EN
               best_mag <= win_mag;
`endif
               if (scan_end && !found) bus.o_singular <= 1'b1;
            end
            SWAP: begin
               if (piv_row != k) begin
                  for (int cc = 0; cc <= N; cc++) begin
                     a[k][cc]       <= a[piv_row][cc];
                     a[piv_row][cc] <= a[k][cc];
                  end
               end
               d_mag   <= mag(a[piv_row][CB'(k)]);
               d_neg   <= a[piv_row][CB'(k)][W-1];
               rem     <= '0;
               quot    <= '0;
               div_sr  <= DIV_INIT;
               div_cnt <= CNT_INIT;
            end
            RECIP: begin
               rem     <= rem_ge ? rem_sub[W-1:0] : rem_sh[W-1:0];
               quot    <= {quot[QW-2:0], rem_ge};
               div_sr  <= div_sr << 1;
               div_cnt <= div_cnt - CNT_ONE;
               j       <= CB'(k);
            end
            NORM: begin
               a[k][j] <= (j == CB'(k)) ? ONE : mul(a[k][j], recip);
               j       <= j + C_ONE;
               i       <= first_i;
            end
            ELIM_F: begin
               fac <= a[i][CB'(k)];
               j   <= CB'(k);
            end
            ELIM: begin
               a[i][j] <= (j == CB'(k)) ? '0 : sat_sub(a[i][j], mul(fac, a[k][j]));
               j       <= j + C_ONE;
               if (j == LAST_COL) i <= nxt_i;
            end
            NEXT: begin
               k <= k + R_ONE;
               r <= k + R_ONE;
            end
            DONE: begin
               for (int rr = 0; rr < N; rr++)
                  bus.o_roots[W*rr +: W] <= bus.o_singular ? '0 : a[rr][LAST_COL];
               bus.o_ready <= 1'b1;
               bus.o_busy  <= 1'b0;
            end
            default: ;
         endcase
      end
   end
endmodule
